// File: rtl/sia_dispatch.sv
// sia_dispatch: hands one proof-of-work job at a time to a bank of siacore
// instances, splits the 32-bit nonce space evenly between them, waits for the
// first find or a timeout, aborts the bank, waits for it to go idle and then
// presents a single result.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where both
// valid and ready are 1. The producer holds valid and payload stable until the
// transfer. in_valid/in_ready carry jobs in; out_valid/out_ready carry results
// out. in_ready is only high in IDLE, and out_valid is only high in REPORT.
module sia_dispatch #(
    parameter  int NCORES  = 4,
    parameter  int TIMEOUT = 1024,
    localparam int CW      = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    // job offer
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [639:0]           in_work,
    input  logic [63:0]            in_target,
    // per-core launch
    output logic [NCORES-1:0]      core_start,
    output logic                   core_abort,
    output logic [639:0]           core_work,
    output logic [63:0]            core_target,
    output logic [NCORES*32-1:0]   core_nonce_base,
    // per-core status
    input  logic [NCORES-1:0]      core_busy,
    input  logic [NCORES-1:0]      core_found,
    input  logic [NCORES*32-1:0]   core_nonce,
    // result
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_nonce,
    output logic [CW-1:0]          out_core,
    output logic                   out_exhausted,
    // current FSM state, for debug and checkers
    output logic [2:0]             dbg_state
);

    localparam int TW = $clog2(TIMEOUT);

    // Width of each core's share of the nonce space.
    localparam logic [63:0] STEP = 64'h1_0000_0000 / 64'(NCORES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t          state;
    logic [TW-1:0]   tcnt;

    logic            any_found;
    logic [CW-1:0]   win_idx;
    logic [31:0]     win_nonce;

    // Start of core i's nonce range, wrapped to 32 bits.
    function automatic logic [31:0] base_of(input int i);
        logic [63:0] prod;
        prod = STEP * 64'(i);
        return prod[31:0];
    endfunction

    // Lowest-index reporting core wins; scanning downward leaves the lowest last.
    always_comb begin
        any_found = |core_found;
        win_idx   = '0;
        win_nonce = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (core_found[i]) begin
                win_idx   = CW'(i);
                win_nonce = core_nonce[i*32 +: 32];
            end
        end
    end

    // Ready/valid are plain state decodes; in_ready is also held low by rst.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == REPORT);
    assign dbg_state = state;

    // Job sequencing FSM with registered launch, abort and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            tcnt            <= '0;
            core_start      <= '0;
            core_abort      <= 1'b0;
            core_work       <= '0;
            core_target     <= '0;
            core_nonce_base <= '0;
            out_nonce       <= '0;
            out_core        <= '0;
            out_exhausted   <= 1'b0;
        end else begin
            // start and abort are single-cycle pulses
            core_start <= '0;
            core_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        core_work   <= in_work;
                        core_target <= in_target;
                        // bases and start are valid together during LAUNCH
                        core_start  <= '1;
                        for (int i = 0; i < NCORES; i++) begin
                            core_nonce_base[i*32 +: 32] <= base_of(i);
                        end
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tcnt  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    tcnt <= tcnt + TW'(1);
                    // a find on the timeout cycle still counts as a find
                    if (any_found) begin
                        out_nonce     <= win_nonce;
                        out_core      <= win_idx;
                        out_exhausted <= 1'b0;
                        core_abort    <= 1'b1;
                        state         <= DRAIN;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        out_nonce     <= '0;
                        out_core      <= '0;
                        out_exhausted <= 1'b1;
                        core_abort    <= 1'b1;
                        state         <= DRAIN;
                    end
                end
                DRAIN: begin
                    // late finds are ignored; just wait for the bank to idle
                    if (core_busy == '0) begin
                        state <= REPORT;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sia_dispatch.sv
// tb_sia_dispatch: directed vector table plus randomized jobs for sia_dispatch
// with NCORES=4, TIMEOUT=16, including a reset in the middle of a job.
module tb_sia_dispatch;

    localparam int NC = 4;
    localparam int TO = 16;
    localparam int CW = 2;
    localparam int RW = 1 + CW + 32;   // {exhausted, core, nonce}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [639:0]         in_work = '0;
    logic [63:0]          in_target = '0;
    logic [NC-1:0]        core_start;
    logic                 core_abort;
    logic [639:0]         core_work;
    logic [63:0]          core_target;
    logic [NC*32-1:0]     core_nonce_base;
    logic [NC-1:0]        core_busy = '0;
    logic [NC-1:0]        core_found = '0;
    logic [NC*32-1:0]     core_nonce = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [31:0]          out_nonce;
    logic [CW-1:0]        out_core;
    logic                 out_exhausted;
    logic [2:0]           dbg_state;

    sia_dispatch #(.NCORES(NC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_work(in_work), .in_target(in_target),
        .core_start(core_start), .core_abort(core_abort),
        .core_work(core_work), .core_target(core_target),
        .core_nonce_base(core_nonce_base),
        .core_busy(core_busy), .core_found(core_found), .core_nonce(core_nonce),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_nonce(out_nonce), .out_core(out_core), .out_exhausted(out_exhausted),
        .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [RW-1:0] exp_q[$];
    logic [NC*32-1:0] exp_base;
    logic [2:0] idle_code;

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int unsigned  found_cycle;  // RUN cycle (1-based) of the find, 0 = never
        logic [3:0]   found_vec;
        logic [127:0] nonces;       // {core3, core2, core1, core0}
        int unsigned  busy_hold;    // DRAIN cycles with busy still high
        int unsigned  ready_delay;  // REPORT cycles with out_ready low
        bit           drain_found;  // spurious find in the first DRAIN cycle
        logic [31:0]  exp_nonce;
        logic [1:0]   exp_core;
        logic         exp_exh;
    } vec_t;

    vec_t tbl[7];

    // Reference: first RUN cycle within the timeout window with any find
    // reports the lowest set core; otherwise the job is exhausted.
    function automatic logic [RW-1:0] model(input vec_t v);
        logic [3:0] low;
        int idx;
        if (v.found_cycle >= 1 && v.found_cycle <= TO && v.found_vec != 0) begin
            low = v.found_vec & (~v.found_vec + 4'd1);
            idx = $clog2(low);
            return {1'b0, CW'(idx), v.nonces[idx*32 +: 32]};
        end
        return {1'b1, {CW{1'b0}}, 32'h0};
    endfunction

    function automatic logic [639:0] rand_work();
        logic [639:0] w;
        for (int i = 0; i < 20; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // ---------------- driver ----------------
    // Entered and left at posedge+1 with the DUT in IDLE.
    task automatic run_job(input vec_t v, input logic [RW-1:0] exp);
        logic [639:0] w;
        logic [63:0]  t;
        int unsigned  end_k;
        logic [RW-1:0] sb;
        w = rand_work();
        t = {$urandom, $urandom};
        end_k = (v.found_cycle >= 1 && v.found_cycle <= TO && v.found_vec != 0)
                ? v.found_cycle : TO;
        in_valid = 1'b1; in_work = w; in_target = t;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_work = rand_work();  // must not disturb the registered job
        exp_q.push_back(exp);
        // LAUNCH
        @(negedge clk);
        chk("launch_start", core_start, 4'hF);
        chk("launch_base", core_nonce_base, exp_base);
        chk("launch_work", core_work, w);
        chk("launch_target", core_target, t);
        chk("launch_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        // RUN
        core_nonce = v.nonces;
        for (int unsigned k = 1; k <= end_k; k++) begin
            core_busy = '1;
            core_found = (k == v.found_cycle) ? v.found_vec : 4'h0;
            @(negedge clk);
            chk("run_start", core_start, 4'h0);
            chk("run_abort", core_abort, 1'b0);
            chk("run_out_valid", out_valid, 1'b0);
            chk("run_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        // DRAIN
        for (int unsigned d = 1; d <= v.busy_hold + 1; d++) begin
            core_busy = (d <= v.busy_hold) ? 4'hF : 4'h0;
            core_found = (d == 1 && v.drain_found) ? 4'hF : 4'h0;
            @(negedge clk);
            chk("drain_abort", core_abort, (d == 1));
            chk("drain_out_valid", out_valid, 1'b0);
            chk("drain_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        core_found = '0;
        core_busy = '0;
        // REPORT
        if (exp_q.size() == 0) begin
            chk("sb_nonempty", 1'b0, 1'b1);
            sb = '0;
        end else begin
            sb = exp_q.pop_front();
        end
        for (int unsigned r = 0; r <= v.ready_delay; r++) begin
            out_ready = (r == v.ready_delay);
            in_valid = 1'b1;
            @(negedge clk);
            chk("report_valid", out_valid, 1'b1);
            chk("report_result", {out_exhausted, out_core, out_nonce}, sb);
            chk("report_in_ready", in_ready, 1'b0);
            chk("report_work", core_work, w);
            chk("report_abort", core_abort, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("after_report_in_ready", in_ready, 1'b1);
        chk("after_report_valid", out_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_start"}, core_start, 4'h0);
        chk({tag, "_abort"}, core_abort, 1'b0);
        chk({tag, "_nonce"}, out_nonce, 32'h0);
        chk({tag, "_core"}, out_core, 2'd0);
        chk({tag, "_exh"}, out_exhausted, 1'b0);
        chk({tag, "_work"}, core_work, 640'h0);
        chk({tag, "_target"}, core_target, 64'h0);
        chk({tag, "_base"}, core_nonce_base, 128'h0);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [63:0] step;
        vec_t rv;
        step = 64'h1_0000_0000 / NC;
        for (int i = 0; i < NC; i++) begin
            logic [63:0] p;
            p = step * 64'(i);
            exp_base[i*32 +: 32] = p[31:0];
        end

        //           cyc  vec      nonces {c3,c2,c1,c0}                                   busy rdy df  exp_nonce     core  exh
        tbl[0] = '{5,  4'b0100, {32'h0, 32'h8000_0123, 32'h0, 32'h0},                    1,   0,  0, 32'h8000_0123, 2'd2, 1'b0};
        tbl[1] = '{3,  4'b1010, {32'hC000_0020, 32'h0, 32'h4000_0010, 32'h0},            0,   1,  0, 32'h4000_0010, 2'd1, 1'b0};
        tbl[2] = '{0,  4'b0000, {32'h5, 32'h6, 32'h7, 32'h8},                            0,   2,  0, 32'h0,         2'd0, 1'b1};
        tbl[3] = '{7,  4'b0001, {32'h0, 32'h0, 32'h0, 32'h1234_5678},                    2,  10,  0, 32'h1234_5678, 2'd0, 1'b0};
        tbl[4] = '{2,  4'b1000, {32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3},                    7,   0,  1, 32'hDEAD_BEEF, 2'd3, 1'b0};
        tbl[5] = '{16, 4'b0110, {32'h0, 32'h22, 32'h11, 32'h0},                          1,   0,  0, 32'h11,        2'd1, 1'b0};
        tbl[6] = '{1,  4'b1111, {32'hA3, 32'hA2, 32'hA1, 32'hA0},                        3,   1,  1, 32'hA0,        2'd0, 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        idle_code = dbg_state;
        rst = 1'b0;
        #1;
        chk("reset_release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // directed table
        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i], {tbl[i].exp_exh, tbl[i].exp_core, tbl[i].exp_nonce});
        end

        // randomized jobs against the reference model
        for (int n = 0; n < 25; n++) begin
            rv.found_cycle = $urandom_range(0, 20);
            rv.found_vec   = 4'($urandom_range(0, 15));
            rv.nonces      = {$urandom, $urandom, $urandom, $urandom};
            rv.busy_hold   = $urandom_range(0, 4);
            rv.ready_delay = $urandom_range(0, 3);
            rv.drain_found = 1'($urandom_range(0, 1));
            rv.exp_nonce   = '0;
            rv.exp_core    = '0;
            rv.exp_exh     = 1'b0;
            run_job(rv, model(rv));
        end

        // reset in the middle of RUN
        in_valid = 1'b1; in_work = rand_work(); in_target = {$urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        core_busy = '1;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        chk("midrst_state", dbg_state, idle_code);
        @(posedge clk); #1;
        core_busy = '0;
        rst = 1'b0;
        #1;
        chk("midrst_release_in_ready", in_ready, 1'b1);
        chk("midrst_no_abort", core_abort, 1'b0);
        @(posedge clk); #1;
        run_job(tbl[0], model(tbl[0]));

        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // hard time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
